fcore_istore_scheduler: RTL and testbench
=========================================

# fcore_istore_scheduler

Sequencer and arbiter for the fCore instruction store read port. It generates the program fetch address stream for one program run. It drives the read-port select so that AXI readback only reaches the memory while no program is executing. Sits between the core control logic (run trigger, program length) and the istore's `dma_read_addr` / `enable_bus_read` inputs.

## Interface
Parameters:
- `MEM_DEPTH`, 4096: istore depth in instructions; `ADDR_WIDTH = $clog2(MEM_DEPTH)`.
- `DRAIN_CYCLES`, 2: cycles after the last fetch before the run is complete (memory read latency plus core pipeline). Legal range is 1..15.

Ports:
- `clock_in`  in  1: single clock for the whole block.
- `reset`  in  1: synchronous reset, active-high.
- `run`  in  1: start pulse for a program run.
- `program_length`  in  ADDR_WIDTH+1: number of instructions to fetch. Sampled only when a run is accepted.
- `abort`  in  1: terminates a run in progress.
- `fetch_addr`  out  ADDR_WIDTH: goes to the istore `dma_read_addr`.
- `fetch_valid`  out  1: `fetch_addr` is a live fetch this cycle.
- `busy`  out  1: a run is in progress (FETCH or DRAIN state).
- `done`  out  1: one-cycle pulse when a run completes normally.
- `run_overrun`  out  1: one-cycle pulse when a `run` is dropped.
- `bus_read_req`  in  1: level request for AXI readback access.
- `bus_read_done`  in  1: pulse marking the end of the readback transaction.
- `bus_read_grant`  out  1: goes to the istore `enable_bus_read`.

## Operation
- Every output is registered.
- Reset values of all outputs are 0. The state resets to IDLE and `run_pending` resets to 0.
- States: IDLE, FETCH, DRAIN, BUS.
- IDLE:
  - Priority order is `run` or `run_pending`, then `bus_read_req`.
  - On a run, the length is latched and clamped to MEM_DEPTH if larger.
  - A latched length of 0 gives a `done` pulse on the next cycle and the state stays IDLE.
  - Otherwise the state goes to FETCH with `fetch_addr` = 0.
  - With `bus_read_req` and no run, the state goes to BUS.
- FETCH:
  - `fetch_valid` = 1 and `fetch_addr` increments by 1 each cycle.
  - After address `length-1` the state goes to DRAIN.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles, counted by a down-counter.
  - `fetch_valid` = 0 and `fetch_addr` holds its last value.
  - `done` is high during the final DRAIN cycle; the state then goes to IDLE.
- BUS:
  - `bus_read_grant` = 1 until `bus_read_done`, then the state goes to IDLE.
  - `fetch_addr` = 0 and `fetch_valid` = 0.
- `run` handling outside IDLE:
  - `run` in BUS sets `run_pending`. `run_pending` is cleared when the run is accepted; a second `run` while pending is ignored and raises no overrun.
  - `run` in FETCH or DRAIN is dropped and pulses `run_overrun` on the next cycle.
- `abort`:
  - In FETCH or DRAIN it forces IDLE on the next cycle.
  - `fetch_valid` and `busy` go to 0, no `done` is issued, and `fetch_addr` returns to 0.
  - It is ignored in IDLE and BUS.
- `bus_read_req` in FETCH or DRAIN waits; there is no preemption of a running program.
- `bus_read_done` outside BUS is ignored.
- `reset` mid-run or mid-grant:
  - It takes effect on the next edge.
  - `bus_read_grant` drops immediately and `run_pending` is cleared.

## Timing
- `run` sampled at edge N leads to FETCH from cycle N+1.
  - Address k is presented at cycle N+1+k.
  - The last address (`length-1`) is at cycle N+length.
- DRAIN covers cycles N+length+1 .. N+length+DRAIN_CYCLES.
  - `done` is high at cycle N+length+DRAIN_CYCLES.
  - IDLE is reached one cycle later.
- `busy` is high from N+1 through the `done` cycle inclusive.
- A new `run` can be accepted in the first IDLE cycle, giving a 1-cycle idle gap between runs.
- `bus_read_req` seen in IDLE at cycle M gives `bus_read_grant` high from M+1.
- `bus_read_done` at cycle P gives grant low at P+1, with the state IDLE at P+1.
  - A pending run is accepted at P+1 and FETCH starts at P+2.
- Grant and `fetch_valid` are never high in the same cycle.
- `fetch_addr` never exceeds MEM_DEPTH-1. With length = MEM_DEPTH the last address is MEM_DEPTH-1; there is no wrap to 0 while valid.

## Test plan
- Normal run, DRAIN_CYCLES=2, `run` with length 5 at cycle 10.
  - Required: `fetch_valid` high cycles 11-15 with addresses 0..4, `done` at cycle 17, `busy` cycles 11-17.
- Length 0, and length 8191 with MEM_DEPTH 4096.
  - Length 0 gives `done` the next cycle and no fetch.
  - Length 8191 fetches 0..4095 and stops at 4095.
- Readback: `bus_read_req` high in IDLE, `bus_read_done` 20 cycles later.
  - Required: grant high for exactly 20 cycles.
  - Required: `run` pulsed mid-grant starts FETCH 2 cycles after `bus_read_done`.
- Contention and overrun.
  - `run` and `bus_read_req` in the same IDLE cycle: the run wins and the grant waits until after `done`.
  - `run` during FETCH pulses `run_overrun` and does not extend the run.
- `abort` at fetch address 3 of a length-10 run.
  - Required: IDLE next cycle, no `done`, `fetch_addr` = 0.
  - Required: a following `run` behaves normally.
- `reset` asserted during DRAIN and during BUS.
  - Required: all outputs 0 next cycle and `run_pending` cleared.
  - Required: grant does not reassert until `bus_read_req` is seen in IDLE again.

Source files
------------

// File: rtl/fcore_istore_scheduler.sv
// Program fetch sequencer and read-port arbiter for the fCore instruction store.
// Runs own the port in FETCH/DRAIN; AXI readback gets it only from IDLE via BUS.
module fcore_istore_scheduler #(
    parameter int unsigned MEM_DEPTH    = 4096,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                          clock_in,
    input  logic                          reset,
    input  logic                          run,
    input  logic [$clog2(MEM_DEPTH):0]    program_length,
    input  logic                          abort,
    output logic [$clog2(MEM_DEPTH)-1:0]  fetch_addr,
    output logic                          fetch_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          run_overrun,
    input  logic                          bus_read_req,
    input  logic                          bus_read_done,
    output logic                          bus_read_grant
);

    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;
    localparam int unsigned CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_BUS   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   pending_q, pending_d;
    logic [ADDR_WIDTH-1:0]  last_q, last_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0]  fetch_addr_q, fetch_addr_d;
    logic                   fetch_valid_q, fetch_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic                   grant_q, grant_d;

    logic                   run_go;
    logic [LEN_WIDTH-1:0]   len_clamp;
    logic                   len_zero;
    logic [ADDR_WIDTH-1:0]  last_addr;
    logic                   fetch_last;

    // Oversized lengths saturate at the memory depth so the address never wraps.
    assign run_go     = run | pending_q;
    assign len_clamp  = (program_length > LEN_WIDTH'(MEM_DEPTH)) ? LEN_WIDTH'(MEM_DEPTH)
                                                                 : program_length;
    assign len_zero   = (len_clamp == '0);
    assign last_addr  = ADDR_WIDTH'(len_clamp - LEN_WIDTH'(1));
    assign fetch_last = (fetch_addr_q == last_q);

    // State and output registers
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pending_q     <= 1'b0;
            last_q        <= '0;
            cnt_q         <= '0;
            fetch_addr_q  <= '0;
            fetch_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
            grant_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            fetch_addr_q  <= fetch_addr_d;
            fetch_valid_q <= fetch_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
            grant_q       <= grant_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (run_go) begin
                    pending_d = 1'b0;
                    if (!len_zero) begin
                        state_d = S_FETCH;
                        last_d  = last_addr;
                    end
                end else if (bus_read_req) begin
                    state_d = S_BUS;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (fetch_last) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_WIDTH'(DRAIN_CYCLES - 1);
                end
            end
            S_DRAIN: begin
                if (abort || cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_BUS: begin
                if (run) begin
                    pending_d = 1'b1;
                end
                if (bus_read_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output next values, registered above
    always_comb begin
        fetch_valid_d = (state_d == S_FETCH);
        busy_d        = (state_d == S_FETCH) || (state_d == S_DRAIN);
        grant_d       = (state_d == S_BUS);
        overrun_d     = run && ((state_q == S_FETCH) || (state_q == S_DRAIN));
        done_d        = 1'b0;
        fetch_addr_d  = '0;

        if (state_q == S_IDLE && run_go && len_zero) begin
            done_d = 1'b1;
        end
        if (state_q == S_FETCH && !abort && fetch_last && DRAIN_CYCLES == 1) begin
            done_d = 1'b1;
        end
        if (state_q == S_DRAIN && !abort && cnt_q == CNT_WIDTH'(1)) begin
            done_d = 1'b1;
        end

        if (state_q == S_FETCH && state_d == S_FETCH) begin
            fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
        end else if (state_d == S_DRAIN) begin
            fetch_addr_d = fetch_addr_q;
        end
    end

    assign fetch_addr     = fetch_addr_q;
    assign fetch_valid    = fetch_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign run_overrun    = overrun_q;
    assign bus_read_grant = grant_q;

endmodule

// File: tb/tb_fcore_istore_scheduler.sv
// Directed bench for fcore_istore_scheduler (MEM_DEPTH=4096, DRAIN_CYCLES=2).
module tb_fcore_istore_scheduler;

    localparam int unsigned AW = 12;

    logic          clock_in = 1'b0;
    logic          reset;
    logic          run;
    logic [AW:0]   program_length;
    logic          abort;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid;
    logic          busy;
    logic          done;
    logic          run_overrun;
    logic          bus_read_req;
    logic          bus_read_done;
    logic          bus_read_grant;

    int errors = 0;
    int checks = 0;

    fcore_istore_scheduler #(.MEM_DEPTH(4096), .DRAIN_CYCLES(2)) dut (
        .clock_in       (clock_in),
        .reset          (reset),
        .run            (run),
        .program_length (program_length),
        .abort          (abort),
        .fetch_addr     (fetch_addr),
        .fetch_valid    (fetch_valid),
        .busy           (busy),
        .done           (done),
        .run_overrun    (run_overrun),
        .bus_read_req   (bus_read_req),
        .bus_read_done  (bus_read_done),
        .bus_read_grant (bus_read_grant)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; outputs are observed 1ns after the edge.
    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_outs"}, {27'd0, fetch_valid, busy, done, run_overrun, bus_read_grant}, 32'd0);
        chk({tag, "_addr"}, 32'(fetch_addr), 32'd0);
    endtask

    // Called in the first FETCH cycle; optionally pulses run at fetch index inj.
    task automatic check_run(input int nfetch, input int inj);
        for (int i = 0; i < nfetch; i++) begin
            chk("fetch_valid", 32'(fetch_valid), 32'd1);
            chk("fetch_addr", 32'(fetch_addr), 32'(i));
            chk("busy_fetch", 32'(busy), 32'd1);
            chk("done_fetch", 32'(done), 32'd0);
            chk("grant_fetch", 32'(bus_read_grant), 32'd0);
            chk("overrun_fetch", 32'(run_overrun), 32'((i > 0) && (i - 1 == inj)));
            run = (i == inj);
            tick();
        end
        run = 1'b0;
        chk("drain_valid", 32'(fetch_valid), 32'd0);
        chk("drain_addr", 32'(fetch_addr), 32'(nfetch - 1));
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_done", 32'(done), 32'd0);
        chk("drain_overrun", 32'(run_overrun), 32'(inj == nfetch - 1));
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_valid", 32'(fetch_valid), 32'd0);
        tick();
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_valid", 32'(fetch_valid), 32'd0);
        chk("post_grant", 32'(bus_read_grant), 32'd0);
    endtask

    task automatic start_run(input int len);
        program_length = (AW+1)'(len);
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    initial begin
        int gcount;
        reset = 1'b1; run = 1'b0; program_length = '0; abort = 1'b0;
        bus_read_req = 1'b0; bus_read_done = 1'b0;
        tick();
        tick();
        chk_quiet("reset");
        reset = 1'b0;
        tick();
        chk_quiet("after_reset");

        // Normal run, run sampled in cycle 10
        for (int c = 4; c < 10; c++) tick();
        start_run(5);
        check_run(5, -1);

        // Back-to-back: accepted in the first IDLE cycle
        start_run(3);
        check_run(3, -1);

        // Length 0: done next cycle, no fetch
        program_length = '0;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_valid", 32'(fetch_valid), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        tick();
        chk_quiet("len0_after");

        // Oversized length saturates at 4096 fetches
        start_run(8191);
        check_run(4096, -1);

        // Readback for 20 cycles with a run pulsed mid-grant
        program_length = (AW+1)'(3);
        bus_read_req = 1'b1;
        tick();
        gcount = 0;
        for (int c = 1; c < 20; c++) begin
            gcount += int'(bus_read_grant);
            chk("bus_no_fetch", 32'(fetch_valid), 32'd0);
            chk("bus_addr", 32'(fetch_addr), 32'd0);
            run = (c == 10);
            tick();
        end
        run = 1'b0;
        gcount += int'(bus_read_grant);
        bus_read_done = 1'b1;
        bus_read_req = 1'b0;
        tick();
        bus_read_done = 1'b0;
        chk("grant_cycles", 32'(gcount), 32'd20);
        chk_quiet("bus_released");
        tick();
        check_run(3, -1);

        // Run and bus request together: run wins, grant after done
        bus_read_req = 1'b1;
        start_run(2);
        check_run(2, -1);
        tick();
        chk("grant_after_run", 32'(bus_read_grant), 32'd1);
        bus_read_done = 1'b1;
        bus_read_req = 1'b0;
        tick();
        bus_read_done = 1'b0;
        chk_quiet("contention_end");

        // Run during FETCH is dropped with an overrun pulse
        start_run(6);
        check_run(6, 2);

        // Abort at fetch address 3 of a length-10 run
        start_run(10);
        for (int i = 0; i < 3; i++) tick();
        chk("abort_at_addr", 32'(fetch_addr), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_quiet("abort_idle");
        tick();
        chk_quiet("abort_no_done");
        start_run(4);
        check_run(4, -1);

        // Reset during DRAIN
        start_run(2);
        tick();
        tick();
        chk("in_drain_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_quiet("reset_drain");
        tick();
        chk_quiet("reset_drain_no_done");

        // Reset during BUS with a pending run
        bus_read_req = 1'b1;
        tick();
        chk("bus_grant_on", 32'(bus_read_grant), 32'd1);
        run = 1'b1;
        tick();
        run = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_read_req = 1'b0;
        chk_quiet("reset_bus");
        tick();
        chk_quiet("reset_bus_no_pending");
        tick();
        chk_quiet("reset_bus_idle");
        bus_read_req = 1'b1;
        tick();
        chk("regrant", 32'(bus_read_grant), 32'd1);
        bus_read_done = 1'b1;
        bus_read_req = 1'b0;
        tick();
        bus_read_done = 1'b0;
        chk_quiet("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
